// File: rtl/lfsr_keystream_ctrl.sv
// lfsr_keystream_ctrl: sequences an external LFSR (load, warm-up, shift)
// and packs its serial output MSB-first into bytes with valid/ready.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   start, abort      run request (IDLE only) / synchronous cancel
//   seed_in, num_bytes  run parameters, captured when start is accepted
//   lfsr_shift_en     LFSR shift enable
//   lfsr_par_load     LFSR parallel load
//   lfsr_seed         captured seed for the LFSR load
//   lfsr_ser_out      LFSR serial bit, value before the current shift
//   byte_out, byte_valid, byte_ready  keystream byte handshake
//   busy, done        run in progress / normal completion pulse
module lfsr_keystream_ctrl #(
    parameter int SEED_W = 80,
    parameter int WARMUP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [SEED_W-1:0] seed_in,
    input  logic [7:0]        num_bytes,
    output logic              lfsr_shift_en,
    output logic              lfsr_par_load,
    output logic [SEED_W-1:0] lfsr_seed,
    input  logic              lfsr_ser_out,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WARM,
        S_SHIFT,
        S_HOLD,
        S_FIN
    } state_t;

    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WW-1:0] WARM_LAST =
        WW'((WARMUP > 0) ? WARMUP - 1 : 0);

    state_t              state_q, state_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic [7:0]          num_q, num_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          byte_q, byte_d;
    logic [2:0]          bit_q, bit_d;
    logic [WW-1:0]       warm_q, warm_d;
    logic                shift_en_q, shift_en_d;
    logic                par_load_q, par_load_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        warm_d  = warm_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (num_bytes != 8'd0) begin
                        state_d = S_LOAD;
                        seed_d  = seed_in;
                        num_d   = num_bytes;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_LOAD: begin
                warm_d  = '0;
                bit_d   = 3'd0;
                state_d = (WARMUP > 0) ? S_WARM : S_SHIFT;
            end
            S_WARM: begin
                if (warm_q == WARM_LAST) begin
                    state_d = S_SHIFT;
                    bit_d   = 3'd0;
                end else begin
                    warm_d = warm_q + WW'(1);
                end
            end
            S_SHIFT: begin
                // MSB-first: the first sampled bit ends up in bit 7
                byte_d = {byte_q[6:0], lfsr_ser_out};
                bit_d  = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                bit_d = 3'd0;
                if (valid_q && byte_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = (cnt_d == num_q) ? S_FIN : S_SHIFT;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort wins over every transition; partial byte is dropped
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            byte_d  = 8'd0;
        end

        // outputs are registered: decode them from the next state
        shift_en_d = (state_d == S_WARM) || (state_d == S_SHIFT);
        par_load_d = (state_d == S_LOAD);
        valid_d    = (state_d == S_HOLD);
        done_d     = (state_d == S_FIN);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            seed_q     <= '0;
            num_q      <= 8'd0;
            cnt_q      <= 8'd0;
            byte_q     <= 8'd0;
            bit_q      <= 3'd0;
            warm_q     <= '0;
            shift_en_q <= 1'b0;
            par_load_q <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
            warm_q     <= warm_d;
            shift_en_q <= shift_en_d;
            par_load_q <= par_load_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign lfsr_shift_en = shift_en_q;
    assign lfsr_par_load = par_load_q;
    assign lfsr_seed     = seed_q;
    assign byte_out      = byte_q;
    assign byte_valid    = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_lfsr_keystream_ctrl.sv
// tb_lfsr_keystream_ctrl: directed bench for lfsr_keystream_ctrl with
// WARMUP=0 and WARMUP=16 instances, scripted bits and a real LFSR.
module tb_lfsr_keystream_ctrl;

    localparam int SW = 80;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start0 = 1'b0;
    logic          start16 = 1'b0;
    logic          abort = 1'b0;
    logic          byte_ready = 1'b0;
    logic          use_lfsr = 1'b0;
    logic [SW-1:0] seed_in = '0;
    logic [7:0]    num_bytes = 8'd0;

    logic          se0, pl0, ser0, bv0, busy0, done0;
    logic [SW-1:0] seed0;
    logic [7:0]    bo0;
    logic          se16, pl16, ser16, bv16, busy16, done16;
    logic [SW-1:0] seed16;
    logic [7:0]    bo16;

    logic [63:0]   scr0 = '0;
    logic [63:0]   scr16 = '0;
    int            sp0 = 0;
    int            sp16 = 0;
    logic [SW-1:0] lfsr_s = '0;
    int            overlap = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_keystream_ctrl #(.SEED_W(SW), .WARMUP(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort),
        .seed_in(seed_in), .num_bytes(num_bytes),
        .lfsr_shift_en(se0), .lfsr_par_load(pl0), .lfsr_seed(seed0),
        .lfsr_ser_out(ser0), .byte_out(bo0), .byte_valid(bv0),
        .byte_ready(byte_ready), .busy(busy0), .done(done0)
    );

    lfsr_keystream_ctrl #(.SEED_W(SW), .WARMUP(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .abort(abort),
        .seed_in(seed_in), .num_bytes(num_bytes),
        .lfsr_shift_en(se16), .lfsr_par_load(pl16), .lfsr_seed(seed16),
        .lfsr_ser_out(ser16), .byte_out(bo16), .byte_valid(bv16),
        .byte_ready(byte_ready), .busy(busy16), .done(done16)
    );

    function automatic logic [SW-1:0] lfsr_next(input logic [SW-1:0] s);
        return {s[SW-2:0], s[79] ^ s[61] ^ s[60] ^ s[49]};
    endfunction

    // expected two bytes after 16 warm-up shifts
    function automatic logic [15:0] lfsr_model(input logic [SW-1:0] seed);
        logic [SW-1:0] s;
        logic [15:0]   r;
        s = seed;
        r = '0;
        for (int i = 0; i < 16; i++) s = lfsr_next(s);
        for (int i = 0; i < 16; i++) begin
            r = {r[14:0], s[SW-1]};
            s = lfsr_next(s);
        end
        return r;
    endfunction

    // scripted bit queues: first bit at [63], advanced on each shift
    always @(posedge clk) begin
        if (pl0) sp0 <= 0;
        else if (se0) sp0 <= sp0 + 1;
        if (pl16) sp16 <= 0;
        else if (se16) sp16 <= sp16 + 1;
        if (pl16) lfsr_s <= seed16;
        else if (se16) lfsr_s <= lfsr_next(lfsr_s);
        if ((pl0 && se0) || (pl16 && se16)) overlap <= overlap + 1;
    end

    assign ser0 = (sp0 < 64) ? scr0[6'(63 - sp0)] : 1'b0;
    assign ser16 = use_lfsr ? lfsr_s[SW-1] :
                   ((sp16 < 64) ? scr16[6'(63 - sp16)] : 1'b0);

    task automatic chk(input string nm, input logic [SW-1:0] act,
                       input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_u0(input logic [SW-1:0] sd, input logic [7:0] n);
        seed_in   = sd;
        num_bytes = n;
        start0    = 1'b1;
        step();
        start0    = 1'b0;
    endtask

    typedef struct {
        logic [SW-1:0] seed;
        logic [7:0]    bits;
        logic [7:0]    exp;
    } vec_t;

    vec_t vt[4];

    initial begin
        int nsh, t, cnt, bad;
        logic [15:0] mb;

        vt[0] = '{80'h123456789ABCDEF01234, 8'b10110010, 8'hB2};
        vt[1] = '{80'h1, 8'b00000001, 8'h01};
        vt[2] = '{80'hFFFF, 8'b10000000, 8'h80};
        vt[3] = '{80'hDEAD, 8'b11100101, 8'hE5};

        // reset state
        step();
        step();
        chk("rst_byte_out", SW'(bo0), 0);
        chk("rst_valid", SW'(bv0), 0);
        chk("rst_busy", SW'(busy0), 0);
        chk("rst_done", SW'(done0), 0);
        chk("rst_shift", SW'(se0), 0);
        chk("rst_load", SW'(pl0), 0);
        chk("rst_seed", seed0, 0);
        rst = 1'b1;
        step();

        // single-byte runs, WARMUP=0
        for (int i = 0; i < 4; i++) begin
            scr0 = {vt[i].bits, 56'h0};
            byte_ready = 1'b1;
            start_u0(vt[i].seed, 8'd1);
            chk("v_load", SW'(pl0), 1);
            chk("v_load_noshift", SW'(se0), 0);
            chk("v_seed", seed0, vt[i].seed);
            nsh = 0;
            for (int k = 0; k < 8; k++) begin
                step();
                if (se0 && !bv0) nsh++;
            end
            chk("v_shift_cycles", SW'(nsh), 8);
            step();
            chk("v_valid", SW'(bv0), 1);
            chk("v_byte", SW'(bo0), SW'(vt[i].exp));
            step();
            chk("v_done", SW'(done0), 1);
            chk("v_valid_off", SW'(bv0), 0);
            step();
            chk("v_done_off", SW'(done0), 0);
            chk("v_idle", SW'(busy0), 0);
        end

        // backpressure over two bytes
        scr0 = {8'hC3, 8'h3C, 48'h0};
        byte_ready = 1'b0;
        start_u0(80'hABC, 8'd2);
        for (int k = 0; k < 9; k++) step();
        chk("bp_valid", SW'(bv0), 1);
        chk("bp_byte1", SW'(bo0), 8'hC3);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bo0 !== 8'hC3 || se0 !== 1'b0 || bv0 !== 1'b1) bad++;
        end
        chk("bp_stable", SW'(bad), 0);
        byte_ready = 1'b1;
        step();
        chk("bp_shift2", SW'(se0), 1);
        chk("bp_no_early_done", SW'(done0), 0);
        for (int k = 0; k < 8; k++) step();
        chk("bp_valid2", SW'(bv0), 1);
        chk("bp_byte2", SW'(bo0), 8'h3C);
        step();
        chk("bp_done", SW'(done0), 1);
        step();

        // num_bytes = 0
        start_u0(80'h55, 8'd0);
        chk("n0_busy", SW'(busy0), 1);
        chk("n0_done", SW'(done0), 1);
        chk("n0_noload", SW'(pl0), 0);
        chk("n0_noshift", SW'(se0), 0);
        step();
        chk("n0_busy_off", SW'(busy0), 0);
        chk("n0_done_off", SW'(done0), 0);

        // abort on SHIFT cycle 4, start mid-run ignored
        scr0 = {8'hFF, 56'h0};
        start_u0(80'h77, 8'd1);
        step();
        step();
        seed_in   = 80'h99;
        num_bytes = 8'd7;
        start0    = 1'b1;
        step();
        start0 = 1'b0;
        chk("ab_seed_kept", seed0, 80'h77);
        step();
        abort = 1'b1;
        step();
        chk("ab_busy", SW'(busy0), 0);
        chk("ab_shift", SW'(se0), 0);
        chk("ab_valid", SW'(bv0), 0);
        chk("ab_done", SW'(done0), 0);
        chk("ab_byte", SW'(bo0), 0);
        start0    = 1'b1;
        num_bytes = 8'd1;
        step();
        chk("ab_start_ignored", SW'(busy0), 0);
        chk("ab_start_noload", SW'(pl0), 0);
        abort  = 1'b0;
        start0 = 1'b0;
        step();
        chk("ab_no_done", SW'(done0), 0);

        // warm-up discards the first 16 bits, WARMUP=16
        scr16 = {16'hFFFF, 8'h5A, 40'h0};
        byte_ready = 1'b1;
        seed_in = 80'h1;
        num_bytes = 8'd1;
        start16 = 1'b1;
        step();
        start16 = 1'b0;
        t = 0;
        while (!bv16 && t < 60) begin
            step();
            t++;
        end
        chk("wu_latency", SW'(t), 25);
        chk("wu_byte", SW'(bo16), 8'h5A);
        step();
        chk("wu_done", SW'(done16), 1);
        step();

        // real LFSR, two bytes, spacing
        use_lfsr = 1'b1;
        mb = lfsr_model(80'hC0FFEE0123456789ABCD);
        seed_in = 80'hC0FFEE0123456789ABCD;
        num_bytes = 8'd2;
        start16 = 1'b1;
        step();
        start16 = 1'b0;
        t = 0;
        while (!bv16 && t < 60) begin
            step();
            t++;
        end
        chk("lf_lat", SW'(t), 25);
        chk("lf_byte1", SW'(bo16), SW'(mb[15:8]));
        step();
        t = 1;
        while (!bv16 && t < 60) begin
            step();
            t++;
        end
        chk("lf_spacing", SW'(t), 9);
        chk("lf_byte2", SW'(bo16), SW'(mb[7:0]));
        step();
        chk("lf_done", SW'(done16), 1);
        step();
        use_lfsr = 1'b0;

        // 255 bytes, counter must not wrap
        start_u0(80'h3, 8'd255);
        cnt = 0;
        t = 0;
        while (!done0 && t < 3000) begin
            step();
            t++;
            if (bv0) cnt++;
        end
        chk("n255_done", SW'(done0), 1);
        chk("n255_count", SW'(cnt), 255);
        step();

        // async reset during HOLD
        byte_ready = 1'b0;
        scr0 = {8'hA5, 56'h0};
        start_u0(80'h1234, 8'd1);
        for (int k = 0; k < 9; k++) step();
        chk("rh_valid", SW'(bv0), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rh_byte", SW'(bo0), 0);
        chk("rh_valid_off", SW'(bv0), 0);
        chk("rh_busy", SW'(busy0), 0);
        chk("rh_done", SW'(done0), 0);
        chk("rh_shift", SW'(se0), 0);
        chk("rh_load", SW'(pl0), 0);
        chk("rh_seed", seed0, 0);
        step();
        rst = 1'b1;
        byte_ready = 1'b1;
        step();
        step();
        chk("rh_idle", SW'(busy0), 0);

        chk("no_overlap", SW'(overlap), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
